ddr_port_arbiter: RTL and testbench
===================================

# ddr_port_arbiter

Two-master arbiter that shares the single combined-address-channel DDR port (aid/aaddr/alen/atype command, W, R, B channels) between two requesters, e.g. the DMA and CPU paths ahead of the DDR controller or its simulation model. One transaction is in flight at a time. Round-robin grant by default. Each burst is tracked by a beat counter loaded from alen, and R/B responses are routed back to the granted master only.

## Interface
- DW, 128, data width (128 or 256); strobe width DW/8
- mem_clk  in  1  port clock
- resetn  in  1  reset, asynchronous, active-low
- sN_aid, sN_aaddr, sN_alen, sN_asize, sN_aburst, sN_alock, sN_atype (N=0,1)  in  8/32/8/3/2/2/1  master N command; atype 1=write, 0=read
- sN_avalid  in  1 / sN_aready  out  1  master N command handshake
- sN_wdata, sN_wstrb, sN_wlast, sN_wvalid  in  DW/DW/8/1/1  master N write data
- sN_wready  out  1  master N write ready
- sN_rid, sN_rdata, sN_rresp, sN_rlast, sN_rvalid  out  8/DW/2/1/1  master N read data
- sN_rready  in  1  master N read ready
- sN_bid, sN_bvalid  out  8/1 / sN_bready  in  1  master N write response
- m_aid … m_atype, m_avalid  out  (as sN)  command to DDR port; m_aready  in  1
- m_wdata, m_wstrb, m_wlast, m_wvalid  out / m_wready  in  write data to DDR port
- m_rid, m_rdata, m_rresp, m_rlast, m_rvalid  in / m_rready  out  read data from DDR port
- m_bid, m_bvalid  in / m_bready  out  write response from DDR port

## Operation
- States: IDLE, ADDR, WDATA, BRESP, RDATA.
- IDLE: if either sN_avalid is high, the picker selects a winner. Register grant, load beat_cnt <= sN_alen, go to ADDR. With no request, stay in IDLE.
- Round-robin: on a conflict, the master not served last wins. rr_last is updated at transaction completion.
- ADDR: m_* command fields are muxed from the granted master, and m_avalid=1. sN_aready = m_aready for the granted master only. When m_avalid & m_aready, go to WDATA if atype=1, else RDATA.
- WDATA: W channel passes through from the granted master. m_wvalid = sG_wvalid. sG_wready = m_wready. On each beat, decrement beat_cnt. Exit to BRESP on the beat accepted with beat_cnt==0; wlast is forwarded but is not used for sequencing.
- BRESP: m_bready = sG_bready. sG_bvalid = m_bvalid. Exit to IDLE on m_bvalid & sG_bready.
- RDATA: m_rready = sG_rready. sG_rvalid = m_rvalid. Decrement beat_cnt per beat. Exit to IDLE on the beat accepted with beat_cnt==0.
- Non-granted master: aready, wready, rvalid, rlast and bvalid are held at 0. The rdata/rid/rresp/bid data fields are broadcast to both masters and are don't-care when the corresponding valid is low.
- Outside its own state, each m_ handshake output (avalid, wvalid, rready, bready) is 0.
- beat_cnt is 8 bits. alen=0 means 1 beat and alen=255 means 256 beats; no wrap occurs inside a burst.

## Timing
- Reset values: state=IDLE, grant=0, rr_last=1 (master 0 wins first), beat_cnt=0. All valid/ready outputs are 0, and all data/id outputs are 0.
- Arbitration latency: sN_avalid seen in cycle t gives m_avalid=1 in cycle t+1.
- Grant is held from ADDR until the return to IDLE. A new request cannot be accepted in the cycle the previous transaction completes, so IDLE lasts at least 1 cycle between transactions.
- Simultaneous sN_avalid in IDLE: resolved by rr_last (or fixed priority, see Configuration).
- Reset mid-burst: asynchronous return to IDLE, and all handshake outputs drop immediately. Any partial burst is abandoned.
- All outputs not listed as muxed are registered. Mux outputs depend only on the registered grant and state plus the passed-through channel signals.

## Configuration
- DDR_ARB_FIXED_PRIO_EN defined: master 0 always wins conflicts, and rr_last is neither updated nor used.
- DDR_ARB_FIXED_PRIO_EN undefined: round-robin as above.

## Structure
- Package ddr_arb_pkg holds:
  - state encoding localparams: IDLE=0, ADDR=1, WDATA=2, BRESP=3, RDATA=4
  - NUM_MASTERS=2
  - ATYPE_WRITE=1'b1
- Sub-module ddr_arb_pick: combinational picker with inputs req[1:0] and rr_last, and outputs gnt_valid and gnt_idx. It contains the DDR_ARB_FIXED_PRIO_EN switch.

## Test plan
- Single write: s0 issues alen=3, atype=1, with 4 W beats. Required: m_avalid at t+1, 4 m_wvalid beats, then s0_bvalid pulses once; s1 sees no valid/ready.
- Single read: s1 issues alen=0, atype=0. Required: exactly one s1_rvalid beat carrying m_rdata, then the arbiter returns to IDLE; s0_rvalid stays 0 throughout.
- Contention: s0 and s1 both raise avalid in the same cycle, repeated for 4 transactions. Required grant order is 0,1,0,1; with DDR_ARB_FIXED_PRIO_EN it is 0,0,0,0 while s0 keeps requesting.
- Backpressure: a read with alen=7 where sG_rready toggles every cycle. Required: 8 beats delivered in order, and beat_cnt exits on the 8th accepted beat.
- Max burst: a write with alen=255. Required: exactly 256 W beats forwarded before BRESP, with no counter wrap.
- Reset mid-write: resetn deasserted after 2 of 4 beats. Required: all valid/ready outputs are 0 immediately. After release, a new s1 request is granted normally.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared state encoding and constants for the DDR port arbiter
package ddr_arb_pkg;

  localparam int NUM_MASTERS = 2;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] WDATA = 3'd2;
  localparam logic [2:0] BRESP = 3'd3;
  localparam logic [2:0] RDATA = 3'd4;

  localparam logic ATYPE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = IDLE,
    ST_ADDR  = ADDR,
    ST_WDATA = WDATA,
    ST_BRESP = BRESP,
    ST_RDATA = RDATA
  } arb_state_e;

endpackage

// File: rtl/ddr_arb_pick.sv
// rtl/ddr_arb_pick.sv - two-way request picker; DDR_ARB_FIXED_PRIO_EN selects fixed priority
module ddr_arb_pick
  import ddr_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   rr_last,
  output logic                   gnt_valid,
  output logic                   gnt_idx
);

`ifdef DDR_ARB_FIXED_PRIO_EN
  logic unused_rr_last;
  assign unused_rr_last = rr_last;
`endif

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (req == 2'b11) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
      gnt_idx = 1'b0;
`else
      // On a conflict the master not served last wins.
      gnt_idx = ~rr_last;
`endif
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - shares one DDR command/W/R/B port between two masters, one burst at a time
// DDR_ARB_FIXED_PRIO_EN: master 0 always wins conflicts instead of round-robin
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int DW = 128
) (
  input  logic            mem_clk,
  input  logic            resetn,

  input  logic [7:0]      s0_aid,
  input  logic [31:0]     s0_aaddr,
  input  logic [7:0]      s0_alen,
  input  logic [2:0]      s0_asize,
  input  logic [1:0]      s0_aburst,
  input  logic [1:0]      s0_alock,
  input  logic            s0_atype,
  input  logic            s0_avalid,
  output logic            s0_aready,
  input  logic [DW-1:0]   s0_wdata,
  input  logic [DW/8-1:0] s0_wstrb,
  input  logic            s0_wlast,
  input  logic            s0_wvalid,
  output logic            s0_wready,
  output logic [7:0]      s0_rid,
  output logic [DW-1:0]   s0_rdata,
  output logic [1:0]      s0_rresp,
  output logic            s0_rlast,
  output logic            s0_rvalid,
  input  logic            s0_rready,
  output logic [7:0]      s0_bid,
  output logic            s0_bvalid,
  input  logic            s0_bready,

  input  logic [7:0]      s1_aid,
  input  logic [31:0]     s1_aaddr,
  input  logic [7:0]      s1_alen,
  input  logic [2:0]      s1_asize,
  input  logic [1:0]      s1_aburst,
  input  logic [1:0]      s1_alock,
  input  logic            s1_atype,
  input  logic            s1_avalid,
  output logic            s1_aready,
  input  logic [DW-1:0]   s1_wdata,
  input  logic [DW/8-1:0] s1_wstrb,
  input  logic            s1_wlast,
  input  logic            s1_wvalid,
  output logic            s1_wready,
  output logic [7:0]      s1_rid,
  output logic [DW-1:0]   s1_rdata,
  output logic [1:0]      s1_rresp,
  output logic            s1_rlast,
  output logic            s1_rvalid,
  input  logic            s1_rready,
  output logic [7:0]      s1_bid,
  output logic            s1_bvalid,
  input  logic            s1_bready,

  output logic [7:0]      m_aid,
  output logic [31:0]     m_aaddr,
  output logic [7:0]      m_alen,
  output logic [2:0]      m_asize,
  output logic [1:0]      m_aburst,
  output logic [1:0]      m_alock,
  output logic            m_atype,
  output logic            m_avalid,
  input  logic            m_aready,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  output logic            m_wlast,
  output logic            m_wvalid,
  input  logic            m_wready,
  input  logic [7:0]      m_rid,
  input  logic [DW-1:0]   m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rlast,
  input  logic            m_rvalid,
  output logic            m_rready,
  input  logic [7:0]      m_bid,
  input  logic            m_bvalid,
  output logic            m_bready
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       rr_last_q, rr_last_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;

  logic gnt_valid, gnt_idx;
  logic [NUM_MASTERS-1:0] aready_v, wready_v, rvalid_v, rlast_v, bvalid_v;
  logic [7:0]    rid_b, bid_b;
  logic [DW-1:0] rdata_b;
  logic [1:0]    rresp_b;

  ddr_arb_pick u_pick (
    .req       ({s1_avalid, s0_avalid}),
    .rr_last   (rr_last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Channel signals of the currently granted master.
  logic [7:0]      g_aid, g_alen;
  logic [31:0]     g_aaddr;
  logic [2:0]      g_asize;
  logic [1:0]      g_aburst, g_alock;
  logic            g_atype, g_wlast, g_wvalid, g_rready, g_bready;
  logic [DW-1:0]   g_wdata;
  logic [DW/8-1:0] g_wstrb;

  assign g_aid    = grant_q ? s1_aid    : s0_aid;
  assign g_aaddr  = grant_q ? s1_aaddr  : s0_aaddr;
  assign g_alen   = grant_q ? s1_alen   : s0_alen;
  assign g_asize  = grant_q ? s1_asize  : s0_asize;
  assign g_aburst = grant_q ? s1_aburst : s0_aburst;
  assign g_alock  = grant_q ? s1_alock  : s0_alock;
  assign g_atype  = grant_q ? s1_atype  : s0_atype;
  assign g_wdata  = grant_q ? s1_wdata  : s0_wdata;
  assign g_wstrb  = grant_q ? s1_wstrb  : s0_wstrb;
  assign g_wlast  = grant_q ? s1_wlast  : s0_wlast;
  assign g_wvalid = grant_q ? s1_wvalid : s0_wvalid;
  assign g_rready = grant_q ? s1_rready : s0_rready;
  assign g_bready = grant_q ? s1_bready : s0_bready;

  always_ff @(posedge mem_clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      rr_last_q  <= 1'b1;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_last_q  <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_last_d  = rr_last_q;
    beat_cnt_d = beat_cnt_q;
    m_aid      = '0;
    m_aaddr    = '0;
    m_alen     = '0;
    m_asize    = '0;
    m_aburst   = '0;
    m_alock    = '0;
    m_atype    = 1'b0;
    m_avalid   = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_wlast    = 1'b0;
    m_wvalid   = 1'b0;
    m_rready   = 1'b0;
    m_bready   = 1'b0;
    aready_v   = '0;
    wready_v   = '0;
    rvalid_v   = '0;
    rlast_v    = '0;
    bvalid_v   = '0;
    rid_b      = '0;
    rdata_b    = '0;
    rresp_b    = '0;
    bid_b      = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          grant_d    = gnt_idx;
          beat_cnt_d = gnt_idx ? s1_alen : s0_alen;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_aid              = g_aid;
        m_aaddr            = g_aaddr;
        m_alen             = g_alen;
        m_asize            = g_asize;
        m_aburst           = g_aburst;
        m_alock            = g_alock;
        m_atype            = g_atype;
        m_avalid           = 1'b1;
        aready_v[grant_q]  = m_aready;
        if (m_aready) begin
          state_d = (g_atype == ATYPE_WRITE) ? ST_WDATA : ST_RDATA;
        end
      end
      ST_WDATA: begin
        m_wdata            = g_wdata;
        m_wstrb            = g_wstrb;
        m_wlast            = g_wlast;
        m_wvalid           = g_wvalid;
        wready_v[grant_q]  = m_wready;
        // Burst length comes from beat_cnt alone; wlast is only forwarded.
        if (g_wvalid && m_wready) begin
          if (beat_cnt_q == 8'd0) state_d = ST_BRESP;
          else beat_cnt_d = beat_cnt_q - 8'd1;
        end
      end
      ST_BRESP: begin
        m_bready           = g_bready;
        bvalid_v[grant_q]  = m_bvalid;
        bid_b              = m_bid;
        if (m_bvalid && g_bready) begin
          state_d = ST_IDLE;
`ifndef DDR_ARB_FIXED_PRIO_EN
          rr_last_d = grant_q;
`endif
        end
      end
      ST_RDATA: begin
        m_rready           = g_rready;
        rvalid_v[grant_q]  = m_rvalid;
        rlast_v[grant_q]   = m_rlast;
        rid_b              = m_rid;
        rdata_b            = m_rdata;
        rresp_b            = m_rresp;
        if (m_rvalid && g_rready) begin
          if (beat_cnt_q == 8'd0) begin
            state_d = ST_IDLE;
`ifndef DDR_ARB_FIXED_PRIO_EN
            rr_last_d = grant_q;
`endif
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s0_aready = aready_v[0];
  assign s1_aready = aready_v[1];
  assign s0_wready = wready_v[0];
  assign s1_wready = wready_v[1];
  assign s0_rvalid = rvalid_v[0];
  assign s1_rvalid = rvalid_v[1];
  assign s0_rlast  = rlast_v[0];
  assign s1_rlast  = rlast_v[1];
  assign s0_bvalid = bvalid_v[0];
  assign s1_bvalid = bvalid_v[1];
  assign s0_rid    = rid_b;
  assign s1_rid    = rid_b;
  assign s0_rdata  = rdata_b;
  assign s1_rdata  = rdata_b;
  assign s0_rresp  = rresp_b;
  assign s1_rresp  = rresp_b;
  assign s0_bid    = bid_b;
  assign s1_bid    = bid_b;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - randomized transaction-level bench for ddr_port_arbiter (honours DDR_ARB_FIXED_PRIO_EN)
module tb_ddr_port_arbiter;

  localparam int DW = 128;
  localparam int SW = DW / 8;
  localparam int WQ = DW + SW + 1;
  localparam int RQ = DW + 3;
  localparam int KW = 2 * DW;

  logic mem_clk = 1'b0;
  logic resetn;

  logic [7:0]    s_aid[2];
  logic [31:0]   s_aaddr[2];
  logic [7:0]    s_alen[2];
  logic [2:0]    s_asize[2];
  logic [1:0]    s_aburst[2];
  logic [1:0]    s_alock[2];
  logic          s_atype[2];
  logic [1:0]    s_avalid, s_wlast, s_wvalid, s_rready, s_bready;
  logic [DW-1:0] s_wdata[2];
  logic [SW-1:0] s_wstrb[2];
  logic [1:0]    s_aready, s_wready, s_rlast, s_rvalid, s_bvalid;
  logic [7:0]    s_rid[2];
  logic [DW-1:0] s_rdata[2];
  logic [1:0]    s_rresp[2];
  logic [7:0]    s_bid[2];

  logic [7:0]    m_aid, m_alen, m_rid, m_bid;
  logic [31:0]   m_aaddr;
  logic [2:0]    m_asize;
  logic [1:0]    m_aburst, m_alock, m_rresp;
  logic          m_atype, m_avalid, m_aready, m_wlast, m_wvalid, m_wready;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;
  logic          m_rlast, m_rvalid, m_rready, m_bvalid, m_bready;

  int vectors    = 0;
  int miscompares = 0;
  int rr_model   = 1;

  always #5 mem_clk = ~mem_clk;

  ddr_port_arbiter #(.DW(DW)) dut (
    .mem_clk(mem_clk), .resetn(resetn),
    .s0_aid(s_aid[0]), .s0_aaddr(s_aaddr[0]), .s0_alen(s_alen[0]), .s0_asize(s_asize[0]),
    .s0_aburst(s_aburst[0]), .s0_alock(s_alock[0]), .s0_atype(s_atype[0]),
    .s0_avalid(s_avalid[0]), .s0_aready(s_aready[0]),
    .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wlast(s_wlast[0]),
    .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]),
    .s0_rid(s_rid[0]), .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rlast(s_rlast[0]),
    .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
    .s0_bid(s_bid[0]), .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]),
    .s1_aid(s_aid[1]), .s1_aaddr(s_aaddr[1]), .s1_alen(s_alen[1]), .s1_asize(s_asize[1]),
    .s1_aburst(s_aburst[1]), .s1_alock(s_alock[1]), .s1_atype(s_atype[1]),
    .s1_avalid(s_avalid[1]), .s1_aready(s_aready[1]),
    .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wlast(s_wlast[1]),
    .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]),
    .s1_rid(s_rid[1]), .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rlast(s_rlast[1]),
    .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
    .s1_bid(s_bid[1]), .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]),
    .m_aid(m_aid), .m_aaddr(m_aaddr), .m_alen(m_alen), .m_asize(m_asize),
    .m_aburst(m_aburst), .m_alock(m_alock), .m_atype(m_atype),
    .m_avalid(m_avalid), .m_aready(m_aready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_bid(m_bid), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  task automatic chk(input string tag, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_dw();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Winner of a request pattern, from the arbitration rules alone.
  function automatic int pick_model(input logic [1:0] req);
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
`ifdef DDR_ARB_FIXED_PRIO_EN
    return 0;
`else
    return 1 - rr_model;
`endif
  endfunction

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      s_aid[k] = '0; s_aaddr[k] = '0; s_alen[k] = '0; s_asize[k] = '0;
      s_aburst[k] = '0; s_alock[k] = '0; s_atype[k] = 1'b0;
      s_wdata[k] = '0; s_wstrb[k] = '0;
    end
    s_avalid = '0; s_wlast = '0; s_wvalid = '0; s_rready = '0; s_bready = '0;
    m_aready = 1'b0; m_wready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0;
    m_rlast = 1'b0; m_rvalid = 1'b0; m_bid = '0; m_bvalid = 1'b0;
  endtask

  task automatic setm(input int k, input bit wr, input logic [7:0] len);
    s_aid[k]    = 8'($urandom);
    s_aaddr[k]  = $urandom;
    s_alen[k]   = len;
    s_asize[k]  = 3'($urandom);
    s_aburst[k] = 2'($urandom);
    s_alock[k]  = 2'($urandom);
    s_atype[k]  = wr;
  endtask

  // One transaction: masters in req raise avalid together; a DDR slave model answers.
  task automatic txn(input logic [1:0] req, input int exp_g, input bit tog, input int budget);
    int g, cyc, lat, post, extra, viol, wsent, wrecv, rsent, rrecv, bseen, len;
    bit is_wr, wpend, rpend, bdone, complete;
    logic [7:0] cid;
    logic [WQ-1:0] cur_w, tmpw;
    logic [RQ-1:0] cur_r, tmpr;
    logic [WQ-1:0] wq[$];
    logic [RQ-1:0] rq[$];
    g = -1; cyc = 0; lat = -1; post = 0; extra = 0; viol = 0;
    wsent = 0; wrecv = 0; rsent = 0; rrecv = 0; bseen = 0; len = 0;
    is_wr = 0; wpend = 0; rpend = 0; bdone = 0; complete = 0; cid = '0;
    cur_w = '0; cur_r = '0;
    @(negedge mem_clk);
    while (post < 4 && cyc < budget) begin
      for (int k = 0; k < 2; k++) begin
        s_avalid[k] = !complete && req[k] && (g != k);
        s_wvalid[k] = 1'($urandom_range(0, 1));
        s_wdata[k]  = rnd_dw();
        s_wstrb[k]  = SW'($urandom);
        s_wlast[k]  = 1'($urandom_range(0, 1));
        s_rready[k] = tog ? cyc[0] : ($urandom_range(0, 3) != 0);
        s_bready[k] = ($urandom_range(0, 3) != 0);
      end
      m_aready = ($urandom_range(0, 2) != 0);
      m_wready = ($urandom_range(0, 3) != 0);
      if (g >= 0 && is_wr) begin
        if (wsent <= len) begin
          if (!wpend && $urandom_range(0, 3) != 0) begin
            cur_w = {(wsent == len), rnd_dw(), SW'($urandom)};
            wpend = 1;
          end
          s_wvalid[g] = wpend;
          {s_wlast[g], s_wdata[g], s_wstrb[g]} = cur_w;
        end else begin
          s_wvalid[g] = 1'b1;
        end
      end
      m_bid    = cid;
      m_bvalid = is_wr && (g >= 0) && (wrecv == len + 1) && !bdone;
      m_rid    = cid;
      m_rvalid = 1'b0;
      {m_rlast, m_rresp, m_rdata} = {1'($urandom), 2'($urandom), rnd_dw()};
      if (g >= 0 && !is_wr) begin
        if (rsent <= len) begin
          if (!rpend && $urandom_range(0, 2) != 0) begin
            cur_r = {(rsent == len), 2'($urandom), rnd_dw()};
            rpend = 1;
          end
          m_rvalid = rpend;
          {m_rlast, m_rresp, m_rdata} = cur_r;
        end else begin
          m_rvalid = 1'b1;
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        if (k != g) viol += int'(s_wready[k] | s_rvalid[k] | s_rlast[k] | s_bvalid[k]);
        if (g >= 0 && k != g) viol += int'(s_aready[k]);
      end
      if (g < 0 && s_aready == 2'b11) viol++;
      if (complete) viol += int'(|{s_aready, s_wready, s_rvalid, s_bvalid,
                                   m_avalid, m_wvalid, m_rready, m_bready});
      if (lat < 0 && m_avalid) lat = cyc;
      if (g < 0) begin
        for (int k = 0; k < 2; k++) begin
          if (g < 0 && s_avalid[k] && s_aready[k]) begin
            g = k;
            chk("cmd", {m_aid, m_aaddr, m_alen, m_asize, m_aburst, m_alock, m_atype},
                {s_aid[k], s_aaddr[k], s_alen[k], s_asize[k], s_aburst[k], s_alock[k], s_atype[k]});
            chk("m_hs", {m_avalid, m_aready}, 2'b11);
            is_wr = s_atype[k];
            len   = int'(s_alen[k]);
            cid   = s_aid[k];
          end
        end
      end else begin
        if (is_wr && wpend && s_wvalid[g] && s_wready[g]) begin
          wq.push_back(cur_w);
          wsent++;
          wpend = 0;
        end
        if (s_bvalid[g] && s_bready[g]) begin
          bseen++;
          chk("bid", s_bid[g], cid);
          complete = 1;
        end
      end
      if (m_wvalid && m_wready) begin
        if (wq.size() > 0) begin
          tmpw = wq.pop_front();
          chk("wbeat", {m_wlast, m_wdata, m_wstrb}, tmpw);
          wrecv++;
        end else extra++;
      end
      if (m_bvalid && m_bready) bdone = 1;
      if (m_rvalid && m_rready) begin
        if (g >= 0 && !is_wr && rpend && rsent <= len) begin
          rq.push_back(cur_r);
          rsent++;
          rpend = 0;
        end else extra++;
      end
      if (g >= 0 && s_rvalid[g] && s_rready[g]) begin
        if (rq.size() > 0) begin
          tmpr = rq.pop_front();
          chk("rbeat", {s_rlast[g], s_rresp[g], s_rdata[g]}, tmpr);
          chk("rid", s_rid[g], cid);
          rrecv++;
          if (rrecv == len + 1) complete = 1;
        end else extra++;
      end
      if (complete) post++;
      cyc++;
      @(negedge mem_clk);
    end
    chk("done", complete, 1);
    chk("grant", g, exp_g);
    chk("latency", lat, 1);
    chk("beats", is_wr ? wrecv : rrecv, len + 1);
    if (is_wr) chk("bresp_cnt", bseen, 1);
    chk("extra_beats", extra, 0);
    chk("isolation", viol, 0);
    rr_model = exp_g;
    clear_inputs();
  endtask

  initial begin
    logic [1:0] req;
    int w, cnt;
    bit hs;
    clear_inputs();
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      setm(k, 1'($urandom), 8'($urandom));
      s_wdata[k] = rnd_dw();
    end
    s_avalid = 2'b11; s_wvalid = 2'b11; s_rready = 2'b11; s_bready = 2'b11;
    m_aready = 1'b1; m_wready = 1'b1; m_rvalid = 1'b1; m_bvalid = 1'b1;
    m_rdata = rnd_dw(); m_rid = 8'hA5; m_bid = 8'h5A; m_rresp = 2'b11; m_rlast = 1'b1;
    repeat (3) @(negedge mem_clk);
    #1;
    chk("rst_hs", {m_avalid, m_wvalid, m_rready, m_bready, s_aready, s_wready,
                   s_rvalid, s_rlast, s_bvalid}, 0);
    chk("rst_cmd", {m_aid, m_aaddr, m_alen, m_asize, m_aburst, m_alock, m_atype}, 0);
    chk("rst_wdata", {m_wlast, m_wdata, m_wstrb}, 0);
    chk("rst_rdata0", s_rdata[0], 0);
    chk("rst_rdata1", s_rdata[1], 0);
    chk("rst_ids", {s_rid[0], s_rid[1], s_rresp[0], s_rresp[1], s_bid[0], s_bid[1]}, 0);
    clear_inputs();
    @(negedge mem_clk);
    resetn = 1'b1;
    rr_model = 1;
    repeat (2) @(negedge mem_clk);

    setm(0, 1, 8'd3);
    txn(2'b01, pick_model(2'b01), 0, 500);
    setm(1, 0, 8'd0);
    txn(2'b10, pick_model(2'b10), 0, 500);

    for (int i = 0; i < 4; i++) begin
      setm(0, 1'($urandom), 8'($urandom_range(0, 7)));
      setm(1, 1'($urandom), 8'($urandom_range(0, 7)));
      txn(2'b11, pick_model(2'b11), 0, 800);
    end

    setm(0, 0, 8'd7);
    txn(2'b01, pick_model(2'b01), 1, 800);

    setm(0, 1, 8'd255);
    txn(2'b01, pick_model(2'b01), 0, 4000);

    for (int i = 0; i < 20; i++) begin
      req = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++)
        if (req[k]) setm(k, 1'($urandom), 8'($urandom_range(0, 15)));
      txn(req, pick_model(req), 0, 1500);
    end

    // Reset in the middle of a 4-beat write, after 2 beats.
    setm(0, 1, 8'd3);
    @(negedge mem_clk);
    s_avalid[0] = 1'b1;
    m_aready = 1'b1;
    hs = 0;
    for (int c = 0; c < 20 && !hs; c++) begin
      #1;
      if (s_aready[0]) hs = 1;
      @(negedge mem_clk);
    end
    chk("rst_mid_cmd", hs, 1);
    s_avalid[0] = 1'b0;
    s_wvalid[0] = 1'b1;
    s_wdata[0]  = rnd_dw();
    m_wready    = 1'b1;
    s_rready = 2'b11; s_bready = 2'b11;
    cnt = 0;
    for (w = 0; w < 20; w++) begin
      #1;
      if (m_wvalid && m_wready) cnt++;
      if (cnt == 2) break;
      @(negedge mem_clk);
    end
    chk("rst_mid_beats", cnt, 2);
    @(posedge mem_clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_hs", {m_avalid, m_wvalid, m_rready, m_bready, s_aready, s_wready,
                       s_rvalid, s_rlast, s_bvalid}, 0);
    clear_inputs();
    repeat (2) @(negedge mem_clk);
    resetn = 1'b1;
    rr_model = 1;
    @(negedge mem_clk);
    setm(1, 0, 8'($urandom_range(0, 7)));
    txn(2'b10, pick_model(2'b10), 0, 800);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
